// File: rtl/cnn_stream_pkg.sv
// Shared types and helpers for the CNN pixel-stream blocks.
// Covers the upsampler FSM states, the framing flag bundle and line-buffer style selection.
package cnn_stream_pkg;

    typedef enum logic [1:0] {IDLE, FILL, EMIT0, EMIT1} ups_state_t;

    typedef struct packed {
        logic sop;
        logic eop;
        logic sof;
        logic eof;
    } stream_flags_t;

    typedef enum logic {RAM_LOGIC, RAM_M10K} ram_style_t;

    // Narrow line buffers live in fabric registers; wide ones go to block RAM.
    function automatic ram_style_t ram_style_sel(input int channel_num);
        return (channel_num < 32) ? RAM_LOGIC : RAM_M10K;
    endfunction

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/upsample_nn_2x_ram.sv
// Simple dual-port line-buffer RAM: one synchronous write port, one registered read port.
// RAM_STYLE picks the implementation attribute.
module upsample_nn_2x_ram
    import cnn_stream_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         ADDR_WIDTH = 4,
    parameter int         DEPTH      = 16,
    parameter ram_style_t RAM_STYLE  = RAM_LOGIC
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    generate
        if (RAM_STYLE == RAM_M10K) begin : g_block_ram
            (* ramstyle = "M10K" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

            // NOTE: the array has no reset; a reset term would stop it mapping onto RAM primitives.
            always_ff @(posedge clk) begin
                if (wr_en) mem[wr_addr] <= wr_data;
                if (rd_en) rd_data <= mem[rd_addr];
            end
        end else begin : g_logic_ram
            (* ramstyle = "logic" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en) mem[wr_addr] <= wr_data;
                if (rd_en) rd_data <= mem[rd_addr];
            end
        end
    endgenerate

endmodule

// File: rtl/upsample_nn_2x.sv
// 2x2 nearest-neighbour upsampler for a channel-interleaved pixel stream with sop/eop/sof/eof framing.
// Define UPSAMPLE_ZERO_INSERT_EN to emit data only on the first copy of the first pass (zero insertion).
module upsample_nn_2x
    import cnn_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNEL_NUM = 3,
    parameter int STRING_LEN  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         sop_i,
    input  logic                         eop_i,
    input  logic                         sof_i,
    input  logic                         eof_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         data_valid_o,
    output logic                         sop_o,
    output logic                         eop_o,
    output logic                         sof_o,
    output logic                         eof_o,
    output logic                         err_o
);

    localparam int         N         = CHANNEL_NUM * STRING_LEN;
    localparam int         AW        = clog2_min1(N);
    localparam int         CW        = clog2_min1(CHANNEL_NUM);
    localparam int         PW        = clog2_min1(STRING_LEN);
    localparam ram_style_t RAM_STYLE = ram_style_sel(CHANNEL_NUM);

    ups_state_t    state;
    logic [AW-1:0] wr_cnt;
    logic          frame_start;
    logic          frame_end;
    logic [AW-1:0] base;
    logic [CW-1:0] ch;
    logic          copy_h;
    logic [PW-1:0] pix;

    logic          accept;
    logic          drop;
    logic          wr_last;
    logic          framing_bad;
    logic          rd_en;
    logic          rd_first;
    logic          rd_last;
    logic [AW-1:0] rd_addr;
    logic          rd_zero;
    stream_flags_t rd_flags;

    logic [DATA_WIDTH-1:0] rd_data;
    logic                  s1_valid;
    logic                  s1_zero;
    stream_flags_t         s1_flags;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        accept      = 1'b0;
        drop        = 1'b0;
        wr_last     = 1'b0;
        framing_bad = 1'b0;
        rd_en       = 1'b0;
        rd_first    = 1'b0;
        rd_last     = 1'b0;
        rd_addr     = '0;
        rd_zero     = 1'b0;
        rd_flags    = '0;

        accept  = valid_i && ready_o &&
                  ((state == FILL) || ((state == IDLE) && sof_i && sop_i));
        drop    = valid_i && ready_o && (state == IDLE) && !(sof_i && sop_i);
        wr_last = (wr_cnt == AW'(N - 1));
        framing_bad = ((wr_cnt == '0) && !sop_i) || (eop_i != wr_last);

        rd_en    = (state == EMIT0) || (state == EMIT1);
        rd_first = (pix == '0) && !copy_h && (ch == '0);
        rd_last  = (pix == PW'(STRING_LEN - 1)) && copy_h && (ch == CW'(CHANNEL_NUM - 1));
        rd_addr  = base + AW'(ch);

`ifdef UPSAMPLE_ZERO_INSERT_EN
        rd_zero = !((state == EMIT0) && !copy_h);
`else
        rd_zero = 1'b0;
`endif

        rd_flags.sop = rd_en && rd_first;
        rd_flags.eop = rd_en && rd_last;
        rd_flags.sof = (state == EMIT0) && rd_first && frame_start;
        rd_flags.eof = (state == EMIT1) && rd_last && frame_end;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ready_o     <= 1'b0;
            wr_cnt      <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            base        <= '0;
            ch          <= '0;
            copy_h      <= 1'b0;
            pix         <= '0;
            err_o       <= 1'b0;
        end else begin
            if (drop || (accept && framing_bad)) err_o <= 1'b1;

            case (state)
                IDLE, FILL: begin
                    ready_o <= 1'b1;
                    if (accept) begin
                        if (state == IDLE) frame_start <= 1'b1;
                        if (wr_last) begin
                            wr_cnt    <= '0;
                            frame_end <= eof_i;
                            ready_o   <= 1'b0;
                            state     <= EMIT0;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                            state  <= FILL;
                        end
                    end
                end

                EMIT0, EMIT1: begin
                    // Walk channels, then the two copies, then step the pixel base by CHANNEL_NUM.
                    if (ch == CW'(CHANNEL_NUM - 1)) begin
                        ch     <= '0;
                        copy_h <= ~copy_h;
                        if (copy_h) begin
                            if (pix == PW'(STRING_LEN - 1)) begin
                                pix  <= '0;
                                base <= '0;
                            end else begin
                                pix  <= pix + 1'b1;
                                base <= base + AW'(CHANNEL_NUM);
                            end
                        end
                    end else begin
                        ch <= ch + 1'b1;
                    end

                    if ((state == EMIT0) && rd_first) frame_start <= 1'b0;

                    if (rd_last) begin
                        if (state == EMIT0) begin
                            state <= EMIT1;
                        end else begin
                            state     <= frame_end ? IDLE : FILL;
                            frame_end <= 1'b0;
                            ready_o   <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    upsample_nn_2x_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW),
        .DEPTH      (N),
        .RAM_STYLE  (RAM_STYLE)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_cnt),
        .wr_data (data_i),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Flags ride alongside the RAM read so framing stays aligned while the next line fills.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_zero      <= 1'b0;
            s1_flags     <= '0;
            data_valid_o <= 1'b0;
            data_o       <= '0;
            sop_o        <= 1'b0;
            eop_o        <= 1'b0;
            sof_o        <= 1'b0;
            eof_o        <= 1'b0;
        end else begin
            s1_valid     <= rd_en;
            s1_zero      <= rd_zero;
            s1_flags     <= rd_flags;
            data_valid_o <= s1_valid;
            data_o       <= (s1_valid && !s1_zero) ? rd_data : '0;
            sop_o        <= s1_flags.sop;
            eop_o        <= s1_flags.eop;
            sof_o        <= s1_flags.sof;
            eof_o        <= s1_flags.eof;
        end
    end

endmodule
